snos_fmt_serializer: RTL

//  Parametrised multi-line PCM serializer: buffers parallel samples from i2s_deser in a FIFO.

---
 rtl/snos_fmt_serializer_pkg.sv | 19 +
 rtl/snos_sync_fifo.sv | 46 ++++
 rtl/snos_fmt_serializer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/snos_fmt_serializer_pkg.sv
// Shared types for the PCM serializer: output format encoding and word-length clamp.
// No logic; no latency or backpressure of its own.
package snos_fmt_serializer_pkg;

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_RJ  = 2'd2
  } FMT;

  localparam int BITS_MIN = 16;

  function automatic logic [5:0] clamp_bits(input logic [5:0] b, input int sw);
    if (int'(b) < BITS_MIN) return 6'(BITS_MIN);
    if (int'(b) > sw) return 6'(sw);
    return b;
  endfunction

endpackage

// File: rtl/snos_sync_fifo.sv
// Single-clock FIFO, register storage read at the head pointer; write visible to a pop next cycle.
// Writes are dropped while full and pops ignored while empty; caller gates with full/empty.
module snos_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_pop && !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/snos_fmt_serializer.sv
// Multi-line I2S/LJ/RJ serializer with generated bck/lrck; a buffered frame starts at the next frame start.
// ready drops only when the frame FIFO is full; an empty FIFO at frame start sends zeros and flags underrun.
module snos_fmt_serializer
  import snos_fmt_serializer_pkg::*;
#(
  parameter int PAIRS      = 2,
  parameter int SW         = 32,
  parameter int SLOT       = 32,
  parameter int BCK_HALF   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2*PAIRS*SW-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  en,
  input  FMT                    fmt,
  input  logic [5:0]            bits,
  input  logic                  mute,
  output logic                  bck,
  output logic                  lrck,
  output logic [PAIRS-1:0]      sdata,
  output logic                  underrun
);

  localparam int FW   = 2*PAIRS*SW;
  localparam int DIVW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int CW   = $clog2(2*SLOT);
  localparam int OW   = CW + 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCK_HALF-1);
  localparam logic [CW-1:0]   LAST     = CW'(2*SLOT-1);
  localparam logic [CW-1:0]   SLOT_C   = CW'(SLOT);
  localparam logic [CW-1:0]   SLOT_M1  = CW'(SLOT-1);

  logic [FW-1:0]             fifo_dat;
  logic                      fifo_full;
  logic                      fifo_empty;

  logic [DIVW-1:0]           div_cnt;
  logic [CW-1:0]             bit_cnt;
  logic                      started;
  FMT                        cfg_fmt;
  logic [5:0]                cfg_bits;
  logic                      cfg_mute;
  logic [PAIRS-1:0][SW-1:0]  sr_l;
  logic [PAIRS-1:0][SW-1:0]  sr_r;

  logic                      wrap;
  logic                      fall_tick;
  logic                      frame_start;
  logic [CW-1:0]             bit_nxt;
  logic [CW-1:0]             b_pos;
  logic                      chan;
  logic [OW-1:0]             off;
  logic                      in_word;
  FMT                        nxt_fmt;
  logic [5:0]                nxt_bits;
  logic                      nxt_mute;
  logic                      lrck_nxt;
  logic [PAIRS-1:0][SW-1:0]  cur_l;
  logic [PAIRS-1:0][SW-1:0]  cur_r;
  logic [PAIRS-1:0]          sdata_nxt;

  assign ready = !fifo_full && resetn;

  snos_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_vld (valid && ready),
    .wr_dat (data),
    .rd_pop (frame_start),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    wrap      = en && (div_cnt == DIV_LAST);
    fall_tick = wrap && bck;
    bit_nxt   = (!started || bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
    // The first fall after enable always opens a fresh frame at bit 0.
    frame_start = fall_tick && (!started || bit_nxt == '0);

    nxt_fmt  = frame_start ? fmt : cfg_fmt;
    nxt_bits = frame_start ? clamp_bits(bits, SW) : cfg_bits;
    nxt_mute = frame_start ? mute : cfg_mute;

    cur_l = sr_l;
    cur_r = sr_r;
    if (frame_start) begin
      for (int p = 0; p < PAIRS; p++) begin
        cur_l[p] = (fifo_empty || nxt_mute) ? '0 : fifo_dat[(2*p+2)*SW-1 -: SW];
        cur_r[p] = (fifo_empty || nxt_mute) ? '0 : fifo_dat[(2*p+1)*SW-1 -: SW];
      end
    end

    chan    = (bit_nxt >= SLOT_C);
    b_pos   = chan ? bit_nxt - SLOT_C : bit_nxt;
    off     = (nxt_fmt == FMT_RJ) ? OW'(SLOT) - OW'(nxt_bits) : '0;
    in_word = (OW'(b_pos) >= off) && (OW'(b_pos) < off + OW'(nxt_bits));

    if (nxt_fmt == FMT_I2S) lrck_nxt = (bit_nxt >= SLOT_M1) && (bit_nxt < LAST);
    else                    lrck_nxt = chan;

    for (int p = 0; p < PAIRS; p++)
      sdata_nxt[p] = in_word && (chan ? cur_r[p][SW-1] : cur_l[p][SW-1]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      started  <= 1'b0;
      bck      <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= '0;
      underrun <= 1'b0;
      cfg_fmt  <= FMT_I2S;
      cfg_bits <= 6'(BITS_MIN);
      cfg_mute <= 1'b0;
      sr_l     <= '0;
      sr_r     <= '0;
    end else if (!en) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      started  <= 1'b0;
      bck      <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && fifo_empty;
      div_cnt  <= wrap ? '0 : div_cnt + DIVW'(1);
      if (wrap) bck <= !bck;
      if (fall_tick) begin
        bit_cnt  <= bit_nxt;
        started  <= 1'b1;
        cfg_fmt  <= nxt_fmt;
        cfg_bits <= nxt_bits;
        cfg_mute <= nxt_mute;
        lrck     <= lrck_nxt;
        sdata    <= sdata_nxt;
        // Only the channel currently emitting a word bit advances its shift register.
        for (int p = 0; p < PAIRS; p++) begin
          sr_l[p] <= (in_word && !chan) ? {cur_l[p][SW-2:0], 1'b0} : cur_l[p];
          sr_r[p] <= (in_word &&  chan) ? {cur_r[p][SW-2:0], 1'b0} : cur_r[p];
        end
      end
    end
  end

endmodule
